// File: rtl/user_pattern_gen_pkg.sv
// Shared user-side stream constants, the FSM state type and the tkeep helpers
// used by the pattern generator.
package user_pattern_gen_pkg;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 32;
  localparam int BCNT_W = 64;
  localparam int BEAT_W = 16;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  function automatic logic [3:0] popcount(input logic [KEEP_W-1:0] k);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_W; i++) cnt = cnt + 4'(k[i]);
    return cnt;
  endfunction

  // A length that is a whole number of beats keeps every lane on the final beat.
  function automatic logic [KEEP_W-1:0] last_keep(input int len);
    int r;
    r = len % KEEP_W;
    if (r == 0) return '1;
    return KEEP_W'((1 << r) - 1);
  endfunction
endpackage

// File: rtl/user_pattern_gen_if.sv
// AXI-stream style beat bus between the pattern generator and user_data.
interface user_pattern_gen_if;
  logic                                  tvalid;
  logic                                  tready;
  logic [user_pattern_gen_pkg::DATA_W-1:0] tdata;
  logic [user_pattern_gen_pkg::KEEP_W-1:0] tkeep;

  modport master (output tvalid, tdata, tkeep, input tready);
  modport slave  (input tvalid, tdata, tkeep, output tready);
endinterface

// File: rtl/user_pattern_gen.sv
// Emits runs of fixed-length segments carrying an incrementing byte pattern,
// separated by GAP_CYCLES idle cycles, with a sticky stop and segment limit.
module user_pattern_gen
  import user_pattern_gen_pkg::*;
#(
  parameter int TCP_DATA_LENGTH = 1456,
  parameter int GAP_CYCLES      = 16
) (
  input  logic               coreclk_out,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   num_segments,
  user_pattern_gen_if.master m_axis,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   seg_count,
  output logic [BCNT_W-1:0]  byte_count
);
  localparam int               BEATS     = (TCP_DATA_LENGTH + KEEP_W - 1) / KEEP_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [KEEP_W-1:0] LAST_KEEP = last_keep(TCP_DATA_LENGTH);
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [7:0]          gap_q, gap_d;
  logic [BYTE_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    seg_q, seg_d;
  logic [BCNT_W-1:0]   bytes_q, bytes_d;
  logic [CNT_W-1:0]    nseg_q, nseg_d;
  logic                stop_seen_q, stop_seen_d;

  logic                last_beat;
  logic [KEEP_W-1:0]   cur_keep;
  logic [3:0]          beat_bytes;
  logic [DATA_W-1:0]   pattern;

  assign last_beat  = (beat_q == LAST_BEAT);
  assign cur_keep   = last_beat ? LAST_KEEP : '1;
  assign beat_bytes = popcount(cur_keep);

  // Every lane carries its byte, even lanes masked off on the last beat.
  always_comb begin
    pattern = '0;
    for (int k = 0; k < KEEP_W; k++) pattern[BYTE_W*k +: BYTE_W] = idx_q + BYTE_W'(k);
  end

  assign m_axis.tvalid = (state_q == SEND);
  assign m_axis.tdata  = (state_q == SEND) ? pattern  : '0;
  assign m_axis.tkeep  = (state_q == SEND) ? cur_keep : '0;
  assign busy          = (state_q == SEND) || (state_q == GAP);
  assign done          = (state_q == DONE);
  assign seg_count     = seg_q;
  assign byte_count    = bytes_q;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    seg_d       = seg_q;
    bytes_d     = bytes_q;
    nseg_d      = nseg_q;
    stop_seen_d = stop_seen_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = SEND;
        beat_d      = '0;
        idx_d       = '0;
        seg_d       = '0;
        bytes_d     = '0;
        nseg_d      = num_segments;
        stop_seen_d = stop;
      end
      SEND: begin
        stop_seen_d = stop_seen_q | stop;
        if (m_axis.tready) begin
          idx_d   = idx_q + BYTE_W'(beat_bytes);
          bytes_d = bytes_q + BCNT_W'(beat_bytes);
          if (last_beat) begin
            beat_d = '0;
            gap_d  = '0;
            seg_d  = seg_q + 1'b1;
            if (stop_seen_d || (nseg_q != '0 && seg_d == nseg_q)) state_d = DONE;
            else if (GAP_CYCLES == 0)                             state_d = SEND;
            else                                                  state_d = GAP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      GAP: begin
        stop_seen_d = stop_seen_q | stop;
        if (stop_seen_d)            state_d = DONE;
        else if (gap_q == GAP_LAST) state_d = SEND;
        else                        gap_d   = gap_q + 8'd1;
      end
      DONE: begin
        state_d     = IDLE;
        stop_seen_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge coreclk_out) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      seg_q       <= '0;
      bytes_q     <= '0;
      nseg_q      <= '0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      bytes_q     <= bytes_d;
      nseg_q      <= nseg_d;
      stop_seen_q <= stop_seen_d;
    end
  end
endmodule

// File: tb/tb_user_pattern_gen.sv
// Scoreboard bench: three generator configurations, expected beats and run
// results queued by the stimulus, compared by a single negedge monitor.
module tb_user_pattern_gen;
  import user_pattern_gen_pkg::*;

  localparam int N = 3;
  localparam int LEN  [N] = '{1456, 13, 1456};
  localparam int GAPC [N] = '{16, 3, 0};

  typedef struct packed { logic [63:0] d; logic [7:0] k; } beat_t;
  typedef struct packed { logic [31:0] s; logic [63:0] b; } cnt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  st, sp;
  logic [31:0]   nseg;
  logic          rdy;
  logic          tv  [N];
  logic          bsy [N];
  logic          dn  [N];
  logic [63:0]   td  [N];
  logic [7:0]    tk  [N];
  logic [31:0]   seg [N];
  logic [63:0]   byt [N];

  user_pattern_gen_if ifc [N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign ifc[g].tready = rdy;
    assign tv[g] = ifc[g].tvalid;
    assign td[g] = ifc[g].tdata;
    assign tk[g] = ifc[g].tkeep;
    user_pattern_gen #(.TCP_DATA_LENGTH(LEN[g]), .GAP_CYCLES(GAPC[g])) u_dut (
      .coreclk_out (clk),
      .reset       (reset),
      .start       (st[g]),
      .stop        (sp[g]),
      .num_segments(nseg),
      .m_axis      (ifc[g]),
      .busy        (bsy[g]),
      .done        (dn[g]),
      .seg_count   (seg[g]),
      .byte_count  (byt[g])
    );
  end

  beat_t beat_q [$];
  cnt_t  res_q  [$];
  cnt_t  idle_q [$];
  int    tests = 0;
  int    fails = 0;
  int    xfer_cnt = 0;
  int    act = 0;
  bit    tog = 1'b0;

  // ready toggler: three cycles high, three low while tog is set
  initial begin
    int tcnt;
    tcnt = 0;
    rdy  = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tog) begin tcnt = (tcnt + 1) % 6; rdy = (tcnt < 3); end
      else begin tcnt = 0; rdy = 1'b1; end
    end
  end

  // monitor
  initial begin
    beat_t e;
    cnt_t  c;
    bit    prev_stall;
    logic [63:0] prev_d;
    logic [7:0]  prev_k;
    int    gap_run;
    prev_stall = 1'b0; prev_d = '0; prev_k = '0; gap_run = 0;
    forever begin
      @(negedge clk);
      if (idle_q.size() > 0) begin
        c = idle_q.pop_front();
        tests++;
        if (tv[act] !== 1'b0 || td[act] !== 64'd0 || tk[act] !== 8'd0 || bsy[act] !== 1'b0 ||
            dn[act] !== 1'b0 || seg[act] !== c.s || byt[act] !== c.b) begin
          fails++;
          $display("FAIL idle_state: tv=%0b td=%h tk=%h busy=%0b done=%0b seg=%0d bytes=%0d, want 0/0/0/0/0 seg=%0d bytes=%0d",
                   tv[act], td[act], tk[act], bsy[act], dn[act], seg[act], byt[act], c.s, c.b);
        end
      end
      if (prev_stall && tv[act]) begin
        tests++;
        if (td[act] !== prev_d || tk[act] !== prev_k) begin
          fails++;
          $display("FAIL stall_stable: td=%h tk=%h, held %h/%h", td[act], tk[act], prev_d, prev_k);
        end
      end
      prev_stall = tv[act] && !rdy;
      prev_d = td[act];
      prev_k = tk[act];
      if (tv[act]) begin
        if (gap_run > 0) begin
          tests++;
          if (gap_run != GAPC[act]) begin
            fails++;
            $display("FAIL gap_len: got %0d idle cycles, want %0d", gap_run, GAPC[act]);
          end
        end
        gap_run = 0;
      end else if (bsy[act]) begin
        gap_run++;
      end
      if (tv[act] && rdy) begin
        xfer_cnt++;
        tests++;
        if (beat_q.size() == 0) begin
          fails++;
          $display("FAIL beat: unexpected beat td=%h tk=%h, want none", td[act], tk[act]);
        end else begin
          e = beat_q.pop_front();
          if (td[act] !== e.d || tk[act] !== e.k) begin
            fails++;
            $display("FAIL beat: td=%h tk=%h, want %h/%h", td[act], tk[act], e.d, e.k);
          end
        end
      end
      if (dn[act]) begin
        tests++;
        if (res_q.size() == 0) begin
          fails++;
          $display("FAIL done: unexpected done pulse seg=%0d bytes=%0d", seg[act], byt[act]);
        end else begin
          c = res_q.pop_front();
          if (seg[act] !== c.s || byt[act] !== c.b || beat_q.size() != 0) begin
            fails++;
            $display("FAIL done: seg=%0d bytes=%0d beats_left=%0d, want seg=%0d bytes=%0d beats_left=0",
                     seg[act], byt[act], beat_q.size(), c.s, c.b);
          end
        end
      end
    end
  end

  task automatic push_model(input int len, input int ns);
    beat_t e;
    logic [7:0] idx;
    int beats, r, nb;
    beats = (len + 7) / 8;
    r = len % 8;
    idx = '0;
    for (int s = 0; s < ns; s++)
      for (int b = 0; b < beats; b++) begin
        nb = (b == beats - 1 && r != 0) ? r : 8;
        e.k = 8'((1 << nb) - 1);
        for (int k = 0; k < 8; k++) e.d[8*k +: 8] = idx + 8'(k);
        beat_q.push_back(e);
        idx = idx + 8'(nb);
      end
  endtask

  task automatic do_start(input int g, input int ns, input bit with_stop);
    @(negedge clk);
    nseg = ns; st[g] = 1'b1; sp[g] = with_stop;
    @(negedge clk);
    st[g] = 1'b0; sp[g] = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (dn[act]) return;
    end
    $display("FAIL done_timeout: no done pulse within 20000 cycles");
    $fatal(1);
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 20000; i++) begin
      if (xfer_cnt >= n) return;
      @(negedge clk);
    end
    $display("FAIL xfer_timeout: xfer_cnt=%0d, want %0d", xfer_cnt, n);
    $fatal(1);
  endtask

  task automatic idle_check(input int s, input longint b);
    @(negedge clk); #1;
    idle_q.push_back('{s: 32'(s), b: 64'(b)});
    @(negedge clk); #1;
  endtask

  initial begin
    int base;
    reset = 1'b1; st = '0; sp = '0; nseg = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_check(0, 0);

    // two segments, full rate; a stray start mid-run must be ignored
    act = 0;
    push_model(1456, 2);
    res_q.push_back('{s: 32'd2, b: 64'd2912});
    base = xfer_cnt;
    do_start(0, 2, 1'b0);
    wait_xfers(base + 10);
    do_start(0, 7, 1'b0);
    wait_done();
    idle_check(2, 2912);

    // 13-byte segment: hand-computed beats
    act = 1;
    beat_q.push_back('{d: 64'h0706050403020100, k: 8'hFF});
    beat_q.push_back('{d: 64'h0F0E0D0C0B0A0908, k: 8'h1F});
    res_q.push_back('{s: 32'd1, b: 64'd13});
    do_start(1, 1, 1'b0);
    wait_done();
    idle_check(1, 13);

    // 13-byte segments with stalls; pattern continues across segments
    tog = 1'b1;
    push_model(13, 3);
    res_q.push_back('{s: 32'd3, b: 64'd39});
    do_start(1, 3, 1'b0);
    wait_done();
    tog = 1'b0;
    idle_check(3, 39);

    // full segment with stalls
    act = 0;
    tog = 1'b1;
    push_model(1456, 1);
    res_q.push_back('{s: 32'd1, b: 64'd1456});
    do_start(0, 1, 1'b0);
    wait_done();
    tog = 1'b0;
    idle_check(1, 1456);

    // unlimited run stopped at beat 50 of segment 3
    push_model(1456, 3);
    res_q.push_back('{s: 32'd3, b: 64'd4368});
    base = xfer_cnt;
    do_start(0, 0, 1'b0);
    wait_xfers(base + 2*182 + 50);
    sp[0] = 1'b1;
    @(negedge clk);
    sp[0] = 1'b0;
    wait_done();
    idle_check(3, 4368);

    // back-to-back segments with no gap
    act = 2;
    push_model(1456, 3);
    res_q.push_back('{s: 32'd3, b: 64'd4368});
    do_start(2, 3, 1'b0);
    wait_done();
    idle_check(3, 4368);

    // start and stop together: exactly one segment
    act = 0;
    push_model(1456, 1);
    res_q.push_back('{s: 32'd1, b: 64'd1456});
    do_start(0, 5, 1'b1);
    wait_done();
    idle_check(1, 1456);

    // reset mid-segment, then a fresh run from byte 0
    push_model(1456, 1);
    base = xfer_cnt;
    do_start(0, 1, 1'b0);
    wait_xfers(base + 100);
    reset = 1'b1;
    @(posedge clk); #1;
    beat_q.delete();
    idle_q.push_back('{s: 32'd0, b: 64'd0});
    @(negedge clk); #1;
    reset = 1'b0;
    idle_check(0, 0);
    push_model(1456, 1);
    res_q.push_back('{s: 32'd1, b: 64'd1456});
    do_start(0, 1, 1'b0);
    wait_done();
    idle_check(1, 1456);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
